// File: rtl/modelado_sequencer.sv
// modelado_sequencer: streams stored samples through the Modelado datapath and emits one result per sample.
// Optional feature: define MODELADO_SEQ_CHECKSUM_EN to add a running XOR checksum output of all transferred results.
module modelado_sequencer #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 400,
    parameter int ADDR_W = 9,
    parameter int SETTLE = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W:0]   num_samples,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    output logic [DATA_W-1:0] dp_x,
    input  logic [DATA_W-1:0] dp_result,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_index,
`ifdef MODELADO_SEQ_CHECKSUM_EN
    output logic [DATA_W-1:0] checksum,
`endif
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_SETTLE, S_OUT, S_DONE} state_t;

    localparam logic [ADDR_W:0] DEPTH_C   = (ADDR_W+1)'(DEPTH);
    localparam logic [3:0]      SETTLE_M1 = 4'(SETTLE - 1);

    state_t              state_q, state_d;
    logic [ADDR_W:0]     len_q, len_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [DATA_W-1:0]   dp_x_q, dp_x_d;
    logic                out_valid_q, out_valid_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic [ADDR_W-1:0]   out_index_q, out_index_d;
    logic                last;

    assign last      = {1'b0, idx_q} == len_q - (ADDR_W+1)'(1);
    assign mem_rd    = state_q == S_FETCH;
    assign mem_addr  = idx_q;
    assign dp_x      = dp_x_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_index = out_index_q;
    assign busy      = state_q != S_IDLE;
    assign done      = state_q == S_DONE;

    // Next-state and datapath-register updates for the fetch/settle/output sequence
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        dp_x_d      = dp_x_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_index_d = out_index_q;
        case (state_q)
            S_IDLE: if (start) begin
                len_d   = (num_samples > DEPTH_C) ? DEPTH_C : num_samples;
                idx_d   = '0;
                state_d = (len_d == '0) ? S_DONE : S_FETCH;
            end
            S_FETCH: state_d = S_WAIT;
            S_WAIT: begin
                dp_x_d  = mem_data;
                cnt_d   = '0;
                state_d = S_SETTLE;
            end
            S_SETTLE: if (cnt_q == SETTLE_M1) begin
                out_data_d  = dp_result;
                out_index_d = idx_q;
                out_valid_d = 1'b1;
                state_d     = S_OUT;
            end else begin
                cnt_d = cnt_q + 4'd1;
            end
            S_OUT: if (out_ready) begin
                out_valid_d = 1'b0;
                idx_d       = last ? idx_q : idx_q + 1'b1;
                state_d     = last ? S_DONE : S_FETCH;
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            idx_q       <= '0;
            cnt_q       <= '0;
            dp_x_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_index_q <= '0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            dp_x_q      <= dp_x_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_index_q <= out_index_d;
        end
    end

`ifdef MODELADO_SEQ_CHECKSUM_EN
    logic [DATA_W-1:0] checksum_q, checksum_d;

    assign checksum = checksum_q;

    // Clear on an accepted start, fold in each result as it is handed off
    always_comb begin
        checksum_d = checksum_q;
        if (state_q == S_IDLE && start) checksum_d = '0;
        else if (state_q == S_OUT && out_ready) checksum_d = checksum_q ^ out_data_q;
    end

    // Checksum register
    always_ff @(posedge clk) begin
        if (!rst_n) checksum_q <= '0;
        else        checksum_q <= checksum_d;
    end
`endif

endmodule
